// File: rtl/seg_scan_driver_pkg.sv
// Shared constants and types for the seven-segment scan driver.
// Segment patterns are active-low, bit order {g,f,e,d,c,b,a}.
package seg_pkg;

  localparam int NUM_DIGITS = 4;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef logic [1:0] digit_idx_t;

  // Index 0 is the rightmost (least significant) entry of the concatenation.
  localparam logic [15:0][6:0] SEG_MAP = {
    7'b0001110,  // F
    7'b0000110,  // E
    7'b0100001,  // d
    7'b1000110,  // C
    7'b0000011,  // b
    7'b0001000,  // A
    7'b0010000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

endpackage

// File: rtl/seg_scan_driver_if.sv
// Load handshake between the upstream datapath and the scan driver.
interface seg_scan_driver_if;

  logic        load;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic        ready;

  modport master (output load, output value, output dp_in, input ready);
  modport slave  (input load, input value, input dp_in, output ready);

endinterface

// File: rtl/seg_scan_driver_hex7seg.sv
// Combinational hex nibble to active-low seven-segment pattern.
module hex7seg
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] pattern
);

  assign pattern = SEG_MAP[nibble];

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed 4-digit common-anode display driver with tear-free frame commit.
// Optional: define SEG_LZ_BLANK_EN for leading-zero blanking of digits 3..1.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int DIV = 100000
) (
  input  logic                clk,
  input  logic                rst_n,
  seg_scan_driver_if.slave    bus,
  output logic [3:0]          an,
  output logic [6:0]          seg,
  output logic                dp,
  output logic                frame_tick
);

  localparam int PCNT_W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [PCNT_W-1:0] pcnt;
  digit_idx_t        idx;
  logic              pending;
  logic [15:0]       shadow_value;
  logic [3:0]        shadow_dp;
  logic [15:0]       disp_value;
  logic [3:0]        disp_dp;

  logic              tick;
  logic              wrap;
  logic [3:0]        nibble;
  logic [6:0]        pattern;
  logic              blank;

  assign tick      = (pcnt == PCNT_W'(DIV - 1));
  assign wrap      = tick && (idx == digit_idx_t'(NUM_DIGITS - 1));
  assign bus.ready = ~pending;
  assign nibble    = disp_value[{idx, 2'b00} +: 4];

  hex7seg u_hex7seg (
    .nibble  (nibble),
    .pattern (pattern)
  );

`ifdef SEG_LZ_BLANK_EN
  // A digit is blank when it and every more-significant nibble are zero.
  always_comb begin
    // NOTE: assigning a default first keeps every path driven, so no latch is inferred.
    blank = 1'b0;
    case (idx)
      2'd3:    blank = (disp_value[15:12] == 4'h0);
      2'd2:    blank = (disp_value[15:8]  == 8'h00);
      2'd1:    blank = (disp_value[15:4]  == 12'h000);
      default: blank = 1'b0;
    endcase
  end
`else
  assign blank = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt         <= '0;
      idx          <= '0;
      pending      <= 1'b0;
      // NOTE: shadow and display are small registers that must read as 0 after reset, so they are reset explicitly.
      shadow_value <= '0;
      shadow_dp    <= '0;
      disp_value   <= '0;
      disp_dp      <= '0;
      frame_tick   <= 1'b0;
      an           <= 4'hF;
      seg          <= SEG_BLANK;
      dp           <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      pcnt       <= tick ? '0 : pcnt + PCNT_W'(1);
      if (tick) idx <= idx + 2'd1;
      frame_tick <= wrap;

      // Commit has priority; ready is low while pending, so a coincident load is dropped.
      if (wrap && pending) begin
        disp_value <= shadow_value;
        disp_dp    <= shadow_dp;
        pending    <= 1'b0;
      end else if (bus.load && !pending) begin
        shadow_value <= bus.value;
        shadow_dp    <= bus.dp_in;
        pending      <= 1'b1;
      end

      an  <= ~(4'b0001 << idx);
      seg <= blank ? SEG_BLANK : pattern;
      dp  <= ~disp_dp[idx];
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Self-checking bench for seg_scan_driver with DIV=4 (one frame = 16 cycles).
module tb_seg_scan_driver;

  localparam int DIV   = 4;
  localparam int FRAME = 4 * DIV;

  typedef struct packed {
    logic [15:0] v;
    logic [3:0]  d;
  } frame_t;

  logic       clk;
  logic       rst_n;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;
  logic       frame_tick;

  seg_scan_driver_if bus ();

  seg_scan_driver #(.DIV(DIV)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus.slave),
    .an         (an),
    .seg        (seg),
    .dp         (dp),
    .frame_tick (frame_tick)
  );

  int checks = 0;
  int errors = 0;
  int cyc;
  frame_t exp_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edges seen since reset release; read at negedges it equals the edge count n.
  always @(posedge clk or negedge rst_n)
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  function automatic logic [6:0] ref_pattern(input logic [3:0] n);
    case (n)
      4'h0: return 7'b1000000;  4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;  4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;  4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;  4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;  4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;  4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;  4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;  default: return 7'b0001110;
    endcase
  endfunction

  function automatic logic [6:0] ref_seg(input logic [15:0] v, input int k);
    logic [3:0] n;
    n = v[k*4 +: 4];
`ifdef SEG_LZ_BLANK_EN
    if (k > 0 && (v >> (4 * k)) == 16'h0) return 7'h7F;
`endif
    return ref_pattern(n);
  endfunction

  task automatic goto(input int n);
    int guard = 0;
    while (cyc < n && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (cyc < n) begin
      errors++;
      $display("FAIL goto_timeout: cyc=%0d wanted %0d", cyc, n);
    end
  endtask

  task automatic drive_load(input logic [15:0] v, input logic [3:0] d);
    bus.load  = 1'b1;
    bus.value = v;
    bus.dp_in = d;
  endtask

  task automatic check_ready(input logic expv, input string tag);
    checks++;
    if (bus.ready !== expv) begin
      errors++;
      $display("FAIL %s: ready=%b expected %b (cyc %0d)", tag, bus.ready, expv, cyc);
    end
  endtask

  // Pops one expected frame and compares the 16 cycles after the wrap edge at 'start'.
  task automatic check_frame(input int start);
    frame_t r;
    int k;
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic e_dp, e_ft;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty: no expected frame for start %0d", start);
      return;
    end
    r = exp_q.pop_front();
    for (int c = start + 1; c <= start + FRAME; c++) begin
      goto(c);
      k     = (c - start - 1) / DIV;
      e_an  = ~(4'b0001 << k);
      e_seg = ref_seg(r.v, k);
      e_dp  = ~r.d[k];
      e_ft  = (c == start + FRAME);
      checks += 4;
      if (an !== e_an) begin
        errors++;
        $display("FAIL an cyc%0d: got %b expected %b", c, an, e_an);
      end
      if (seg !== e_seg) begin
        errors++;
        $display("FAIL seg cyc%0d digit%0d: got %b expected %b", c, k, seg, e_seg);
      end
      if (dp !== e_dp) begin
        errors++;
        $display("FAIL dp cyc%0d digit%0d: got %b expected %b", c, k, dp, e_dp);
      end
      if (frame_tick !== e_ft) begin
        errors++;
        $display("FAIL frame_tick cyc%0d: got %b expected %b", c, frame_tick, e_ft);
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    checks += 5;
    if (an !== 4'hF)         begin errors++; $display("FAIL %s_an: got %b expected 1111", tag, an); end
    if (seg !== 7'h7F)       begin errors++; $display("FAIL %s_seg: got %b expected 1111111", tag, seg); end
    if (dp !== 1'b1)         begin errors++; $display("FAIL %s_dp: got %b expected 1", tag, dp); end
    if (bus.ready !== 1'b1)  begin errors++; $display("FAIL %s_ready: got %b expected 1", tag, bus.ready); end
    if (frame_tick !== 1'b0) begin errors++; $display("FAIL %s_frame_tick: got %b expected 0", tag, frame_tick); end
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    bus.load  = 1'b0;
    bus.value = '0;
    bus.dp_in = '0;
    #32;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    goto(1);
    checks += 2;
    if (an !== 4'b1110)     begin errors++; $display("FAIL first_an: got %b expected 1110", an); end
    if (seg !== 7'b1000000) begin errors++; $display("FAIL first_seg: got %b expected 1000000", seg); end
  endtask

  task automatic test_scan();
    exp_q.push_back('{v: 16'h0000, d: 4'h0});
    check_frame(0);
    exp_q.push_back('{v: 16'h0000, d: 4'h0});
    check_frame(16);
  endtask

  task automatic test_load();
    exp_q.push_back('{v: 16'h0000, d: 4'h0});
    fork
      check_frame(32);
      begin
        goto(37);
        drive_load(16'h1234, 4'h0);
        exp_q.push_back('{v: 16'h1234, d: 4'h0});
        goto(38);
        bus.load = 1'b0;
        check_ready(1'b0, "ready_after_load");
        goto(47);
        check_ready(1'b0, "ready_before_wrap");
        goto(48);
        check_ready(1'b1, "ready_after_wrap");
      end
    join
  endtask

  task automatic test_ignore();
    fork
      check_frame(48);
      begin
        goto(50);
        drive_load(16'hAAAA, 4'b1010);
        exp_q.push_back('{v: 16'hAAAA, d: 4'b1010});
        goto(51);
        bus.load = 1'b0;
        goto(54);
        drive_load(16'h5555, 4'b0101);
        goto(55);
        bus.load = 1'b0;
        goto(63);
        drive_load(16'h5555, 4'b1111);
        goto(64);
        bus.load = 1'b0;
        check_ready(1'b1, "ready_commit_collision");
      end
    join
  endtask

  task automatic test_blank();
    fork
      check_frame(64);
      begin
        goto(68);
        drive_load(16'h0050, 4'b0100);
        exp_q.push_back('{v: 16'h0050, d: 4'b0100});
        goto(69);
        bus.load = 1'b0;
        check_ready(1'b0, "ready_blank_load");
      end
    join
    check_frame(80);
  endtask

  task automatic test_reset_mid();
    goto(98);
    drive_load(16'h9876, 4'hF);
    goto(99);
    bus.load = 1'b0;
    check_ready(1'b0, "ready_pending_before_reset");
    goto(102);
    #1 rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.push_back('{v: 16'h0000, d: 4'h0});
    check_frame(0);
    check_ready(1'b1, "ready_after_mid_reset");
  endtask

  initial begin
    test_reset();
    test_scan();
    test_load();
    test_ignore();
    test_blank();
    test_reset_mid();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover: %0d frames unchecked", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
